// File: rtl/spi_pkg.sv
// Shared SPI master types and default sizing, also used by the receive sequencer.
package spi_pkg;

    localparam int unsigned SPI_N       = 16;
    localparam int unsigned SPI_CLK_DIV = 4;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT_LOW,
        SHIFT_HIGH
    } spi_state_t;

endpackage

// File: rtl/spi_half_period_timer.sv
// Counts CLK_DIV clk cycles while enabled; tick_c marks the last cycle of each half-period.
module spi_half_period_timer
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic clk,
    input  logic n_reset,
    input  logic en_i,
    input  logic restart_i,
    output logic tick_c
);

    localparam int unsigned CW = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick_c = en_i && !restart_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (restart_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_master.sv
// Mode-0 SPI master: one full-duplex N-bit exchange per accepted spi_begin.
// Define SPI_LSB_FIRST_EN for LSB-first shifting in both directions (MSB-first otherwise).
module spi_master
    import spi_pkg::*;
#(
    parameter int unsigned N       = SPI_N,
    parameter int unsigned CLK_DIV = SPI_CLK_DIV
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         spi_begin,
    input  logic [N-1:0] tx_data,
    input  logic         miso,
    output logic         sclk,
    output logic         mosi,
    output logic         spi_ready,
    output logic [N-1:0] rx_data,
    output logic         rx_done
);

    localparam int unsigned BW = $clog2(N + 1);

    spi_state_t    state_q, state_d;
    logic          sclk_q, sclk_d;
    logic          mosi_q, mosi_d;
    logic          ready_q, ready_d;
    logic          rx_done_q, rx_done_d;
    logic [N-1:0]  rx_data_q, rx_data_d;
    logic [N-1:0]  tx_sr_q, tx_sr_d;
    logic [N-1:0]  rx_sr_q, rx_sr_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;

    logic          tick_c;
    logic          first_bit_c;
    logic          next_bit_c;
    logic [N-1:0]  tx_load_c;
    logic [N-1:0]  tx_next_c;
    logic [N-1:0]  rx_next_c;

    // The first bit goes straight to mosi, so the tx register holds only the bits still to send.
`ifdef SPI_LSB_FIRST_EN
    assign first_bit_c = tx_data[0];
    assign tx_load_c   = {1'b0, tx_data[N-1:1]};
    assign next_bit_c  = tx_sr_q[0];
    assign tx_next_c   = {1'b0, tx_sr_q[N-1:1]};
    assign rx_next_c   = {miso, rx_sr_q[N-1:1]};
`else
    assign first_bit_c = tx_data[N-1];
    assign tx_load_c   = {tx_data[N-2:0], 1'b0};
    assign next_bit_c  = tx_sr_q[N-1];
    assign tx_next_c   = {tx_sr_q[N-2:0], 1'b0};
    assign rx_next_c   = {rx_sr_q[N-2:0], miso};
`endif

    spi_half_period_timer #(
        .CLK_DIV (CLK_DIV)
    ) u_timer (
        .clk       (clk),
        .n_reset   (n_reset),
        .en_i      (state_q != IDLE),
        .restart_i (state_q == IDLE),
        .tick_c    (tick_c)
    );

    always_comb begin
        state_d   = state_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        ready_d   = ready_q;
        rx_done_d = 1'b0;
        rx_data_d = rx_data_q;
        tx_sr_d   = tx_sr_q;
        rx_sr_d   = rx_sr_q;
        bit_cnt_d = bit_cnt_q;

        case (state_q)
            IDLE: begin
                if (spi_begin) begin
                    tx_sr_d   = tx_load_c;
                    rx_sr_d   = '0;
                    bit_cnt_d = BW'(N);
                    mosi_d    = first_bit_c;
                    ready_d   = 1'b0;
                    state_d   = SHIFT_LOW;
                end
            end
            SHIFT_LOW: begin
                if (tick_c) begin
                    sclk_d  = 1'b1;
                    rx_sr_d = rx_next_c;
                    state_d = SHIFT_HIGH;
                end
            end
            SHIFT_HIGH: begin
                if (tick_c) begin
                    sclk_d    = 1'b0;
                    bit_cnt_d = bit_cnt_q - BW'(1);
                    if (bit_cnt_q == BW'(1)) begin
                        rx_data_d = rx_sr_q;
                        rx_done_d = 1'b1;
                        ready_d   = 1'b1;
                        mosi_d    = 1'b0;
                        state_d   = IDLE;
                    end else begin
                        tx_sr_d = tx_next_c;
                        mosi_d  = next_bit_c;
                        state_d = SHIFT_LOW;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q   <= IDLE;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            ready_q   <= 1'b1;
            rx_done_q <= 1'b0;
            rx_data_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            ready_q   <= ready_d;
            rx_done_q <= rx_done_d;
            rx_data_q <= rx_data_d;
            tx_sr_q   <= tx_sr_d;
            rx_sr_q   <= rx_sr_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign sclk      = sclk_q;
    assign mosi      = mosi_q;
    assign spi_ready = ready_q;
    assign rx_data   = rx_data_q;
    assign rx_done   = rx_done_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: default 16-bit/div-4 instance plus an 8-bit/div-1 loopback instance.
module tb_spi_master;

    localparam int N   = 16;
    localparam int DIV = 4;
    localparam int LAT = 2 * N * DIV;

    logic        clk;
    logic        n_reset;
    logic        spi_begin;
    logic [15:0] tx_data;
    logic        miso;
    logic        sclk;
    logic        mosi;
    logic        spi_ready;
    logic [15:0] rx_data;
    logic        rx_done;

    logic        begin8;
    logic [7:0]  tx8;
    logic        sclk8;
    logic        mosi8;
    logic        ready8;
    logic [7:0]  rx8;
    logic        done8;

    spi_master u_dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .spi_begin (spi_begin),
        .tx_data   (tx_data),
        .miso      (miso),
        .sclk      (sclk),
        .mosi      (mosi),
        .spi_ready (spi_ready),
        .rx_data   (rx_data),
        .rx_done   (rx_done)
    );

    spi_master #(.N(8), .CLK_DIV(1)) u_dut8 (
        .clk       (clk),
        .n_reset   (n_reset),
        .spi_begin (begin8),
        .tx_data   (tx8),
        .miso      (mosi8),
        .sclk      (sclk8),
        .mosi      (mosi8),
        .spi_ready (ready8),
        .rx_data   (rx8),
        .rx_done   (done8)
    );

    typedef struct {
        logic [15:0] tx;
        logic [15:0] sw;
        logic [15:0] exp_rx;
        logic [15:0] exp_mosi;
    } vec_t;

    vec_t vecs [5];

    int          n_vec;
    int          n_bad;
    int          cyc;
    int          e0;
    int          done_cyc;
    int          first_rise;
    int          rise_cnt;
    int          done_cnt;
    int          slave_idx;
    logic [15:0] slave_word;
    logic [15:0] mosi_word;
    logic [15:0] held_exp;
    logic        held_bad;
    logic        sclk_prev;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic slave_bit(input logic [15:0] w, input int idx);
        if (idx > 15) return 1'b0;
`ifdef SPI_LSB_FIRST_EN
        return w[idx];
`else
        return w[15 - idx];
`endif
    endfunction

    function automatic logic first_tx_bit(input logic [15:0] w);
`ifdef SPI_LSB_FIRST_EN
        return w[0];
`else
        return w[15];
`endif
    endfunction

    // Slave model: presents the next bit after every falling sclk; also records mosi at each rise.
    always @(negedge clk) begin
        if (sclk && !sclk_prev) begin
            rise_cnt = rise_cnt + 1;
            if (rise_cnt == 1) first_rise = cyc;
`ifdef SPI_LSB_FIRST_EN
            mosi_word = {mosi, mosi_word[15:1]};
`else
            mosi_word = {mosi_word[14:0], mosi};
`endif
        end
        if (!sclk && sclk_prev) begin
            slave_idx = slave_idx + 1;
            miso      = slave_bit(slave_word, slave_idx);
        end
        if (rx_done) done_cnt = done_cnt + 1;
        sclk_prev = sclk;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic launch(input logic [15:0] tx, input logic [15:0] sw, input string tag);
        slave_word = sw;
        slave_idx  = 0;
        miso       = slave_bit(sw, 0);
        rise_cnt   = 0;
        done_cnt   = 0;
        first_rise = -1;
        mosi_word  = '0;
        held_bad   = 1'b0;
        spi_begin  = 1'b1;
        tx_data    = tx;
        step();
        e0 = cyc;
        check({tag, "_ready_low"}, 32'(spi_ready), 32'd0);
        check({tag, "_mosi_first"}, 32'(mosi), 32'(first_tx_bit(tx)));
        spi_begin = 1'b0;
        tx_data   = ~tx;
    endtask

    task automatic wait_done(input bit poke, input string tag, output bit ok);
        int k;
        ok = 1'b0;
        for (int i = 0; i < 400 && !ok; i++) begin
            step();
            k = cyc - e0;
            spi_begin = poke && (k == 10 || k == 60);
            if (rx_done) begin
                ok       = 1'b1;
                done_cyc = cyc;
            end else if (rx_data !== held_exp) begin
                held_bad = 1'b1;
            end
        end
        spi_begin = 1'b0;
        if (!ok) begin
            n_vec = n_vec + 1;
            n_bad = n_bad + 1;
            $display("FAIL %s_timeout: no rx_done within 400 cycles, expected at %0d", tag, LAT);
        end
    endtask

    task automatic check_done_now(input logic [15:0] exp_rx, input logic [15:0] exp_mosi,
                                  input string tag);
        check({tag, "_latency"}, 32'(done_cyc - e0), 32'(LAT));
        check({tag, "_first_rise"}, 32'(first_rise - e0), 32'(DIV));
        check({tag, "_rx_data"}, 32'(rx_data), 32'(exp_rx));
        check({tag, "_ready_done"}, 32'(spi_ready), 32'd1);
        check({tag, "_mosi_bits"}, 32'(mosi_word), 32'(exp_mosi));
        check({tag, "_rise_cnt"}, 32'(rise_cnt), 32'd16);
        check({tag, "_rx_held"}, 32'(held_bad), 32'd0);
        check({tag, "_sclk_idle"}, 32'(sclk), 32'd0);
        check({tag, "_mosi_idle"}, 32'(mosi), 32'd0);
        held_exp = exp_rx;
    endtask

    task automatic check_done_after(input string tag);
        step();
        check({tag, "_done_pulse"}, 32'(rx_done), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'd1);
        check({tag, "_ready_after"}, 32'(spi_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit   ok;
        int   bad8;
        int   k8;
        string tag;

        n_vec = 0; n_bad = 0; cyc = 0;
        rise_cnt = 0; done_cnt = 0; slave_idx = 0; first_rise = -1;
        sclk_prev = 1'b0; held_bad = 1'b0; mosi_word = '0; slave_word = '0;
        n_reset = 1'b0; spi_begin = 1'b0; tx_data = '0; miso = 1'b0;
        begin8 = 1'b0; tx8 = '0;

        vecs[0] = '{tx: 16'hB000, sw: 16'h1234, exp_rx: 16'h1234, exp_mosi: 16'hB000};
        vecs[1] = '{tx: 16'hFFFF, sw: 16'h0000, exp_rx: 16'h0000, exp_mosi: 16'hFFFF};
        vecs[2] = '{tx: 16'h0000, sw: 16'hFFFF, exp_rx: 16'hFFFF, exp_mosi: 16'h0000};
        vecs[3] = '{tx: 16'hA5C3, sw: 16'h8001, exp_rx: 16'h8001, exp_mosi: 16'hA5C3};
        vecs[4] = '{tx: 16'h0001, sw: 16'h0001, exp_rx: 16'h0001, exp_mosi: 16'h0001};

        step(); step();
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_ready", 32'(spi_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_done", 32'(rx_done), 32'd0);
        check("rst_ready8", 32'(ready8), 32'd1);
        n_reset = 1'b1;
        held_exp = '0;
        step();

        for (int i = 0; i < 5; i++) begin
            tag = $sformatf("v%0d", i);
            launch(vecs[i].tx, vecs[i].sw, tag);
            wait_done(1'b0, tag, ok);
            if (ok) begin
                check_done_now(vecs[i].exp_rx, vecs[i].exp_mosi, tag);
                check_done_after(tag);
            end
        end

        // Requests during a transfer are dropped, not queued.
        launch(16'h5A3C, 16'hC3A5, "ign");
        wait_done(1'b1, "ign", ok);
        if (ok) begin
            check_done_now(16'hC3A5, 16'h5A3C, "ign");
            check_done_after("ign");
        end

        // Mid-transfer reset aborts at once and publishes nothing.
        launch(16'h7E81, 16'h9999, "rst");
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            step();
            if (rise_cnt == 7) ok = 1'b1;
        end
        check("rst_mid_reached", 32'(ok), 32'd1);
        n_reset = 1'b0;
        #1;
        check("rst_mid_sclk", 32'(sclk), 32'd0);
        check("rst_mid_mosi", 32'(mosi), 32'd0);
        check("rst_mid_ready", 32'(spi_ready), 32'd1);
        check("rst_mid_rx_data", 32'(rx_data), 32'd0);
        step();
        n_reset  = 1'b1;
        held_exp = '0;
        step();
        launch(16'hC0DE, 16'h4321, "post");
        wait_done(1'b0, "post", ok);
        if (ok) begin
            check_done_now(16'h4321, 16'hC0DE, "post");
            check_done_after("post");
        end

        // Back-to-back: second request raised in the completion cycle.
        launch(16'h1357, 16'h2468, "bb1");
        wait_done(1'b0, "bb1", ok);
        if (ok) begin
            check_done_now(16'h2468, 16'h1357, "bb1");
            launch(16'hFEDC, 16'h0F0F, "bb2");
            check("bb2_gap", 32'(e0 - done_cyc), 32'd1);
            wait_done(1'b0, "bb2", ok);
            if (ok) begin
                check_done_now(16'h0F0F, 16'hFEDC, "bb2");
                check_done_after("bb2");
            end
        end

        // 8-bit, divide-by-1 loopback.
        begin8 = 1'b1;
        tx8    = 8'hA5;
        step();
        e0 = cyc;
        check("l8_ready_low", 32'(ready8), 32'd0);
        begin8 = 1'b0;
        tx8    = 8'h00;
        bad8   = 0;
        for (int k = 1; k <= 16; k++) begin
            step();
            k8 = cyc - e0;
            if (32'(sclk8) !== 32'(k8 % 2)) bad8 = bad8 + 1;
            if (k < 16 && done8 !== 1'b0) bad8 = bad8 + 1;
        end
        check("l8_sclk_toggle", 32'(bad8), 32'd0);
        check("l8_rx_data", 32'(rx8), 32'h0000_00A5);
        check("l8_rx_done", 32'(done8), 32'd1);
        check("l8_ready", 32'(ready8), 32'd1);
        step();
        check("l8_done_pulse", 32'(done8), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
